// File: rtl/atm_pkg.sv
// Shared ATM cell layouts, configuration-entry layout and UTOPIA engine state types.
package atm_pkg;

   localparam int CELL_BYTES = 53;
   localparam int NUM_TX_P   = 4;

   typedef struct packed {
      logic [3:0]  gfc;
      logic [7:0]  vpi;
      logic [15:0] vci;
      logic [2:0]  pt;
      logic        clp;
      logic [7:0]  hec;
   } uni_hdr_t;

   typedef struct packed {
      logic [11:0] vpi;
      logic [15:0] vci;
      logic [2:0]  pt;
      logic        clp;
      logic [7:0]  hec;
   } nni_hdr_t;

   typedef struct packed {
      uni_hdr_t         hdr;
      logic [47:0][7:0] payload;
   } uni_cell_t;

   typedef struct packed {
      nni_hdr_t         hdr;
      logic [47:0][7:0] payload;
   } nni_cell_t;

   // Byte 0 of the cell is the most significant byte, i.e. mem[CELL_BYTES-1].
   typedef union packed {
      uni_cell_t                   uni;
      nni_cell_t                   nni;
      logic [CELL_BYTES-1:0][7:0]  mem;
   } ATMCellType;

   typedef struct packed {
      logic [NUM_TX_P-1:0] fwd;
      logic [11:0]         vpi;
   } CellCfgType;

   typedef enum logic [1:0] {
      RX_IDLE    = 2'd0,
      RX_COLLECT = 2'd1,
      RX_HOLD    = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_DONE = 2'd2
   } tx_state_t;

   function automatic logic [5:0] byte_pos(input logic [5:0] idx);
      return 6'(CELL_BYTES - 1) - idx;
   endfunction

endpackage

// File: rtl/cell_cfg_lut.sv
// Cell-configuration table: synchronous write, combinational read (old data on same-cycle collision).
module cell_cfg_lut
   import atm_pkg::*;
#(
   parameter int ASIZE = 8,
   parameter int DSIZE = 16
) (
   input  logic             i_clk,
   input  logic             i_wr_en,
   input  logic [ASIZE-1:0] i_wr_addr,
   input  logic [DSIZE-1:0] i_wr_data,
   input  logic [ASIZE-1:0] i_rd_addr,
   output logic [DSIZE-1:0] o_rd_data
);

   logic [DSIZE-1:0] r_mem [0:(2**ASIZE)-1];

   // Table contents are deliberately left unreset.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/utopia_atm_port.sv
// One ATM-layer switch port: configuration table plus UTOPIA-1 cell receiver and transmitter.
module utopia_atm_port
   import atm_pkg::*;
#(
   parameter int NUM_TX = 4,
   parameter int ASIZE  = 8,
   parameter int DSIZE  = NUM_TX + 12
) (
   input  logic                    i_clk_in,
   input  logic                    i_reset,
   input  logic                    i_lut_wr_en,
   input  logic [ASIZE-1:0]        i_lut_wr_addr,
   input  logic [DSIZE-1:0]        i_lut_wr_data,
   input  logic [ASIZE-1:0]        i_lut_rd_addr,
   output logic [DSIZE-1:0]        o_lut_rd_data,
   input  logic [7:0]              i_rx_data,
   input  logic                    i_rx_soc,
   input  logic                    i_rx_clav,
   output logic                    o_rx_en,
   output logic                    o_rx_valid,
   input  logic                    i_rx_ready,
   output logic [8*CELL_BYTES-1:0] o_rx_cell,
   output logic [7:0]              o_tx_data,
   output logic                    o_tx_soc,
   output logic                    o_tx_en,
   input  logic                    i_tx_clav,
   input  logic                    i_tx_valid,
   input  logic                    i_tx_selected,
   output logic                    o_tx_ready,
   input  logic [8*CELL_BYTES-1:0] i_tx_cell
);

   localparam logic [5:0] LAST_BYTE = 6'(CELL_BYTES - 1);

   cell_cfg_lut #(.ASIZE(ASIZE), .DSIZE(DSIZE)) u_lut (
      .i_clk     (i_clk_in),
      .i_wr_en   (i_lut_wr_en),
      .i_wr_addr (i_lut_wr_addr),
      .i_wr_data (i_lut_wr_data),
      .i_rd_addr (i_lut_rd_addr),
      .o_rd_data (o_lut_rd_data)
   );

   rx_state_t  r_rx_state, w_rx_next;
   logic       r_rx_en, r_rx_valid;
   logic [5:0] r_rx_idx, w_rx_slot;
   logic       w_rx_start, w_rx_store, w_rx_last;
   ATMCellType r_rx_cell;

   tx_state_t  r_tx_state, w_tx_next;
   logic       r_tx_en, r_tx_soc, r_tx_ready;
   logic [7:0] r_tx_data;
   logic [5:0] r_tx_idx;
   logic       w_tx_take, w_tx_fire;
   ATMCellType r_tx_cell;

   // Receiver next state; a byte is taken only while rx_en is low, and soc always restarts the cell.
   always_comb begin
      w_rx_next  = r_rx_state;
      w_rx_start = 1'b0;
      w_rx_store = 1'b0;
      w_rx_last  = 1'b0;
      w_rx_slot  = i_rx_soc ? 6'd0 : r_rx_idx;
      case (r_rx_state)
         RX_IDLE: begin
            if (i_rx_clav && i_rx_ready) begin
               w_rx_start = 1'b1;
               w_rx_next  = RX_COLLECT;
            end else begin
               w_rx_next  = RX_IDLE;
            end
         end
         RX_COLLECT: begin
            if (!r_rx_en && (i_rx_soc || (r_rx_idx != 6'd0))) begin
               w_rx_store = 1'b1;
               w_rx_last  = (w_rx_slot == LAST_BYTE);
            end else begin
               w_rx_store = 1'b0;
            end
            w_rx_next = w_rx_last ? RX_HOLD : RX_COLLECT;
         end
         RX_HOLD: begin
            if (!i_rx_ready) begin
               w_rx_next = RX_IDLE;
            end else begin
               w_rx_next = RX_HOLD;
            end
         end
         default: w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_in or posedge i_reset) begin
      if (i_reset) begin
         r_rx_state <= RX_IDLE;
      end else begin
         r_rx_state <= w_rx_next;
      end
   end

   // Receiver datapath: assembly, stall handshake and delivery flag.
   always_ff @(posedge i_clk_in or posedge i_reset) begin
      if (i_reset) begin
         r_rx_en    <= 1'b1;
         r_rx_valid <= 1'b0;
         r_rx_idx   <= 6'd0;
         r_rx_cell  <= '0;
      end else begin
         case (r_rx_state)
            RX_IDLE: r_rx_en <= ~w_rx_start;
            RX_COLLECT: begin
               if (w_rx_store) begin
                  r_rx_cell.mem[byte_pos(w_rx_slot)] <= i_rx_data;
                  r_rx_idx <= w_rx_slot + 6'd1;
               end
               if (w_rx_last) begin
                  r_rx_en    <= 1'b1;
                  r_rx_valid <= 1'b1;
               end else begin
                  r_rx_en    <= ~i_rx_clav;
               end
            end
            RX_HOLD: begin
               if (!i_rx_ready) begin
                  r_rx_valid <= 1'b0;
                  r_rx_idx   <= 6'd0;
               end
            end
            default: r_rx_en <= 1'b1;
         endcase
      end
   end

   // Transmitter next state; DONE blocks until the core withdraws its offer.
   always_comb begin
      w_tx_next = r_tx_state;
      w_tx_take = 1'b0;
      w_tx_fire = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            if (i_tx_valid && i_tx_selected) begin
               w_tx_take = 1'b1;
               w_tx_next = TX_SEND;
            end else begin
               w_tx_next = TX_IDLE;
            end
         end
         TX_SEND: begin
            if (i_tx_clav) begin
               w_tx_fire = 1'b1;
               w_tx_next = (r_tx_idx == LAST_BYTE) ? TX_DONE : TX_SEND;
            end else begin
               w_tx_next = TX_SEND;
            end
         end
         TX_DONE: begin
            if (!i_tx_valid) begin
               w_tx_next = TX_IDLE;
            end else begin
               w_tx_next = TX_DONE;
            end
         end
         default: w_tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_in or posedge i_reset) begin
      if (i_reset) begin
         r_tx_state <= TX_IDLE;
      end else begin
         r_tx_state <= w_tx_next;
      end
   end

   // Transmitter datapath: latch the offered cell, then serialise one byte per tx_clav cycle.
   always_ff @(posedge i_clk_in or posedge i_reset) begin
      if (i_reset) begin
         r_tx_en    <= 1'b1;
         r_tx_soc   <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tx_ready <= 1'b1;
         r_tx_idx   <= 6'd0;
         r_tx_cell  <= '0;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               r_tx_en  <= 1'b1;
               r_tx_soc <= 1'b0;
               if (w_tx_take) begin
                  r_tx_cell  <= i_tx_cell;
                  r_tx_ready <= 1'b0;
                  r_tx_idx   <= 6'd0;
               end
            end
            TX_SEND: begin
               if (w_tx_fire) begin
                  r_tx_data <= r_tx_cell.mem[byte_pos(r_tx_idx)];
                  r_tx_en   <= 1'b0;
                  r_tx_soc  <= (r_tx_idx == 6'd0);
                  r_tx_idx  <= r_tx_idx + 6'd1;
               end else begin
                  r_tx_en   <= 1'b1;
                  r_tx_soc  <= 1'b0;
               end
            end
            TX_DONE: begin
               r_tx_en  <= 1'b1;
               r_tx_soc <= 1'b0;
               if (!i_tx_valid) begin
                  r_tx_ready <= 1'b1;
               end
            end
            default: r_tx_en <= 1'b1;
         endcase
      end
   end

   assign o_rx_en    = r_rx_en;
   assign o_rx_valid = r_rx_valid;
   assign o_rx_cell  = r_rx_cell;
   assign o_tx_data  = r_tx_data;
   assign o_tx_soc   = r_tx_soc;
   assign o_tx_en    = r_tx_en;
   assign o_tx_ready = r_tx_ready;

endmodule

// File: tb/tb_utopia_atm_port.sv
// Directed bench for utopia_atm_port: table, receiver, transmitter and mid-cell reset.
module tb_utopia_atm_port;
   import atm_pkg::*;

   logic         clk = 1'b0;
   logic         i_reset = 1'b1;
   logic         i_lut_wr_en = 1'b0;
   logic [7:0]   i_lut_wr_addr = 8'h00;
   logic [15:0]  i_lut_wr_data = 16'h0000;
   logic [7:0]   i_lut_rd_addr = 8'h00;
   logic [15:0]  o_lut_rd_data;
   logic [7:0]   i_rx_data = 8'h00;
   logic         i_rx_soc = 1'b0;
   logic         i_rx_clav = 1'b0;
   logic         o_rx_en, o_rx_valid;
   logic         i_rx_ready = 1'b1;
   logic [423:0] o_rx_cell;
   logic [7:0]   o_tx_data;
   logic         o_tx_soc, o_tx_en, o_tx_ready;
   logic         i_tx_clav = 1'b0;
   logic         i_tx_valid = 1'b0;
   logic         i_tx_selected = 1'b0;
   logic [423:0] i_tx_cell = '0;

   int checks = 0;
   int failures = 0;
   logic [7:0] rx_q[$];
   logic       rx_soc_q[$];
   int rx_k, rx_en_hi, rx_early;
   int tx_n, tx_hi, tx_seq_err, tx_soc_err;

   utopia_atm_port dut (
      .i_clk_in(clk), .i_reset(i_reset),
      .i_lut_wr_en(i_lut_wr_en), .i_lut_wr_addr(i_lut_wr_addr), .i_lut_wr_data(i_lut_wr_data),
      .i_lut_rd_addr(i_lut_rd_addr), .o_lut_rd_data(o_lut_rd_data),
      .i_rx_data(i_rx_data), .i_rx_soc(i_rx_soc), .i_rx_clav(i_rx_clav), .o_rx_en(o_rx_en),
      .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready), .o_rx_cell(o_rx_cell),
      .o_tx_data(o_tx_data), .o_tx_soc(o_tx_soc), .o_tx_en(o_tx_en), .i_tx_clav(i_tx_clav),
      .i_tx_valid(i_tx_valid), .i_tx_selected(i_tx_selected), .o_tx_ready(o_tx_ready),
      .i_tx_cell(i_tx_cell)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [423:0] obs, input logic [423:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_rx_en"},    424'(o_rx_en),    424'(1'b1));
      chk({p, "_rx_valid"}, 424'(o_rx_valid), 424'(1'b0));
      chk({p, "_rx_cell"},  o_rx_cell,        '0);
      chk({p, "_tx_en"},    424'(o_tx_en),    424'(1'b1));
      chk({p, "_tx_soc"},   424'(o_tx_soc),   424'(1'b0));
      chk({p, "_tx_data"},  424'(o_tx_data),  424'(8'h00));
      chk({p, "_tx_ready"}, 424'(o_tx_ready), 424'(1'b1));
   endtask

   function automatic logic [423:0] exp_rx_cell();
      logic [423:0] c;
      int base;
      c = '0;
      base = rx_q.size() - 53;
      for (int i = 0; i < 53; i++) c[423-8*i -: 8] = rx_q[base+i];
      return c;
   endfunction

   task automatic rx_load(input int n, input logic [7:0] first, input bit with_soc);
      for (int i = 0; i < n; i++) begin
         rx_q.push_back(first + 8'(i));
         rx_soc_q.push_back(with_soc && (i == 0));
      end
   endtask

   // PHY model: the byte on the bus is consumed at every edge where rx_en was low.
   task automatic rx_drive(input int stall_at, input int stall_len, input int abort_at);
      int cyc, stall_left;
      bit stalled;
      logic en_b;
      rx_k = 0; rx_en_hi = 0; rx_early = 0; cyc = 0; stall_left = 0; stalled = 1'b0;
      while (rx_k < rx_q.size() && rx_k != abort_at && cyc < 500) begin
         i_rx_data = rx_q[rx_k];
         i_rx_soc  = rx_soc_q[rx_k];
         if (rx_k == stall_at && !stalled) begin
            stall_left = stall_len;
            stalled = 1'b1;
         end
         i_rx_clav = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         if (o_rx_en && rx_k > 0) rx_en_hi++;
         if (o_rx_valid) rx_early++;
         en_b = o_rx_en;
         tick();
         if (!en_b) rx_k++;
         cyc++;
      end
      i_rx_soc = 1'b0;
      i_rx_data = 8'h00;
   endtask

   task automatic rx_cell_test(input string p, input int stall_at, input int exp_hi);
      logic [423:0] exp;
      rx_drive(stall_at, 3, -1);
      i_rx_clav = 1'b0;
      exp = exp_rx_cell();
      chk({p, "_consumed"}, 424'(rx_k), 424'(rx_q.size()));
      chk({p, "_valid_rise"}, 424'(o_rx_valid), 424'(1'b1));
      chk({p, "_valid_early"}, 424'(rx_early), 424'(0));
      chk({p, "_en_stall_cycles"}, 424'(rx_en_hi), 424'(exp_hi));
      chk({p, "_cell"}, o_rx_cell, exp);
      tick();
      chk({p, "_hold_valid"}, 424'(o_rx_valid), 424'(1'b1));
      chk({p, "_hold_cell"}, o_rx_cell, exp);
      i_rx_ready = 1'b0;
      tick();
      chk({p, "_valid_drop"}, 424'(o_rx_valid), 424'(1'b0));
      i_rx_ready = 1'b1;
      tick();
   endtask

   task automatic tx_drive(input int pause_at, input int abort_at);
      int cyc, pause_left;
      bit paused;
      logic [7:0] eb;
      tx_n = 0; tx_hi = 0; tx_seq_err = 0; tx_soc_err = 0;
      cyc = 0; pause_left = 0; paused = 1'b0;
      i_tx_clav = 1'b1;
      while (tx_n < 53 && tx_n != abort_at && cyc < 300) begin
         tick();
         cyc++;
         if (!o_tx_en) begin
            eb = 8'hA0 + 8'(tx_n);
            if (o_tx_data !== eb) tx_seq_err++;
            if (o_tx_soc !== (tx_n == 0)) tx_soc_err++;
            tx_n++;
         end else if (tx_n > 0) begin
            tx_hi++;
            if (o_tx_soc) tx_soc_err++;
         end
         if (tx_n == pause_at && !paused) begin
            pause_left = 2;
            paused = 1'b1;
         end
         if (pause_left > 0) begin
            i_tx_clav = 1'b0;
            pause_left--;
         end else begin
            i_tx_clav = 1'b1;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 53; i++) i_tx_cell[423-8*i -: 8] = 8'hA0 + 8'(i);
      tick();
      tick();
      chk_reset("reset");
      i_reset = 1'b0;
      tick();

      // Configuration table, including same-cycle write/read of one address.
      i_lut_wr_en = 1'b1; i_lut_wr_addr = 8'h06; i_lut_wr_data = 16'h0F0F;
      tick();
      i_lut_wr_addr = 8'h05; i_lut_wr_data = 16'h1111;
      tick();
      i_lut_wr_data = 16'h3ABC; i_lut_rd_addr = 8'h05;
      #1 chk("lut_same_cycle_old", 424'(o_lut_rd_data), 424'(16'h1111));
      tick();
      chk("lut_read_05", 424'(o_lut_rd_data), 424'(16'h3ABC));
      i_lut_wr_data = 16'h5555; i_lut_rd_addr = 8'h06;
      #1 chk("lut_other_addr_during_wr", 424'(o_lut_rd_data), 424'(16'h0F0F));
      tick();
      i_lut_wr_en = 1'b0;
      chk("lut_other_addr_after_wr", 424'(o_lut_rd_data), 424'(16'h0F0F));
      i_lut_rd_addr = 8'h05;
      #1 chk("lut_read_05_new", 424'(o_lut_rd_data), 424'(16'h5555));
      tick();

      // Receiver: plain cell, stalled cell, soc re-sync.
      rx_q = {}; rx_soc_q = {};
      rx_load(53, 8'h00, 1'b1);
      rx_cell_test("rx_plain", -1, 0);
      chk("rx_plain_byte0", 424'(o_rx_cell[423:416]), 424'(8'h00));
      chk("rx_plain_byte52", 424'(o_rx_cell[7:0]), 424'(8'h34));

      rx_q = {}; rx_soc_q = {};
      rx_load(53, 8'h40, 1'b1);
      rx_cell_test("rx_stall", 20, 3);

      rx_q = {}; rx_soc_q = {};
      rx_load(10, 8'h80, 1'b1);
      rx_load(53, 8'hC0, 1'b1);
      rx_cell_test("rx_resync", -1, 0);

      // Transmitter: full cell with a 2-cycle tx_clav pause.
      i_tx_valid = 1'b1; i_tx_selected = 1'b1; i_tx_clav = 1'b1;
      tick();
      chk("tx_ready_taken", 424'(o_tx_ready), 424'(1'b0));
      tx_drive(25, -1);
      chk("tx_byte_count", 424'(tx_n), 424'(53));
      chk("tx_byte_order", 424'(tx_seq_err), 424'(0));
      chk("tx_soc_placement", 424'(tx_soc_err), 424'(0));
      chk("tx_pause_cycles", 424'(tx_hi), 424'(2));
      tick(); tick(); tick();
      chk("tx_ready_held", 424'(o_tx_ready), 424'(1'b0));
      chk("tx_en_after_cell", 424'(o_tx_en), 424'(1'b1));
      i_tx_valid = 1'b0; i_tx_selected = 1'b0;
      tick();
      chk("tx_ready_release", 424'(o_tx_ready), 424'(1'b1));
      tick();

      // Reset at rx byte 20, then orphan bytes with no soc must never form a cell.
      rx_q = {}; rx_soc_q = {};
      rx_load(53, 8'h10, 1'b1);
      rx_drive(-1, 0, 20);
      i_rx_clav = 1'b0;
      #2 i_reset = 1'b1;
      #1 chk_reset("rx_abort");
      tick();
      i_reset = 1'b0;
      tick();
      rx_q = {}; rx_soc_q = {};
      rx_load(33, 8'h24, 1'b0);
      rx_drive(-1, 0, -1);
      i_rx_clav = 1'b0;
      chk("rx_abort_no_pulse", 424'(rx_early), 424'(0));
      chk("rx_abort_valid_low", 424'(o_rx_valid), 424'(1'b0));

      // Reset at tx byte 30.
      i_tx_valid = 1'b1; i_tx_selected = 1'b1;
      tick();
      tx_drive(-1, 30);
      chk("tx_abort_progress", 424'(tx_n), 424'(30));
      i_tx_valid = 1'b0; i_tx_selected = 1'b0; i_tx_clav = 1'b0;
      #2 i_reset = 1'b1;
      #1 chk_reset("tx_abort");
      tick();
      i_reset = 1'b0;
      tick();
      tick();
      chk("tx_abort_idle_en", 424'(o_tx_en), 424'(1'b1));
      chk("tx_abort_idle_ready", 424'(o_tx_ready), 424'(1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
